// File: rtl/display_refresh_pkg.sv
// Purpose: shared register map, FSM state type and frame-word helper for the display refresh path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_refresh_pkg;

  // Driver-chip register addresses (upper nibble of the 16-bit frame is always zero)
  localparam logic [3:0] ADDR_DIGIT0     = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1     = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2     = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3     = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4     = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5     = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6     = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7     = 4'h8;
  localparam logic [3:0] ADDR_DECODE     = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY  = 4'hA;
  localparam logic [3:0] ADDR_SCAN_LIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN   = 4'hC;
  localparam logic [3:0] ADDR_TEST       = 4'hF;

  // Index of the last frame in the power-up init sequence (five frames, 0..4)
  localparam logic [2:0] INIT_LAST = 3'd4;
  // Init frame that carries the intensity value
  localparam logic [2:0] INIT_INTENS_IDX = 3'd3;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_DIGITS,
    ST_IDLE,
    ST_INTENS
  } state_t;

  // Build one 16-bit register frame: {don't-care nibble, address, data}
  function automatic logic [15:0] frame_word(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/serial_frame_tx.sv
// Purpose: shifts one 16-bit frame MSB-first onto dout/sclk with load framing.
// Latency: outputs start the cycle after i_start; frame lasts 33*CLK_DIV cycles, o_done on the last one.
// Backpressure: i_start is accepted only while idle or on the o_done cycle; otherwise ignored.
module serial_frame_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [15:0] i_word,
  output logic        o_done,
  output logic        o_dout,
  output logic        o_load,
  output logic        o_sclk
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             active;
  logic             tail;     // trailing half-bit with load high, clk low
  logic             half;     // 0 = clk-low half of the bit, 1 = clk-high half
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_idx;
  logic [15:0]      shreg;    // remaining bits, next one to send at [15]
  logic             phase_end;
  logic             accept;

  assign phase_end = (div_cnt == DIV_LAST);
  assign o_done    = active && tail && phase_end;
  assign accept    = i_start && (!active || o_done);

  // Frame sequencer: divider, bit counter and registered pin levels
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      active  <= 1'b0;
      tail    <= 1'b0;
      half    <= 1'b0;
      div_cnt <= '0;
      bit_idx <= 4'd0;
      shreg   <= 16'h0000;
      o_dout  <= 1'b0;
      o_load  <= 1'b1;
      o_sclk  <= 1'b0;
    end else if (accept) begin
      active  <= 1'b1;
      tail    <= 1'b0;
      half    <= 1'b0;
      div_cnt <= '0;
      bit_idx <= 4'd15;
      shreg   <= {i_word[14:0], 1'b0};
      o_dout  <= i_word[15];
      o_load  <= 1'b0;
      o_sclk  <= 1'b0;
    end else if (active) begin
      if (!phase_end) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end else begin
        div_cnt <= '0;
        if (tail) begin
          active <= 1'b0;
          tail   <= 1'b0;
        end else if (!half) begin
          half   <= 1'b1;
          o_sclk <= 1'b1;
        end else begin
          // Falling clk edge: the only place data is allowed to move
          half   <= 1'b0;
          o_sclk <= 1'b0;
          if (bit_idx == 4'd0) begin
            tail   <= 1'b1;
            o_load <= 1'b1;
            o_dout <= 1'b0;
          end else begin
            bit_idx <= bit_idx - 4'd1;
            o_dout  <= shreg[15];
            shreg   <= {shreg[14:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/display_refresh_controller.sv
// Purpose: sequences init, digit refresh and intensity frames to a MAX7219-style driver.
// Latency: a refresh request in IDLE starts its first frame 2 cycles later; o_busy follows 1 cycle after a request.
// Backpressure: i_en low holds at the next frame boundary; requests arriving while busy coalesce into one refresh.
module display_refresh_controller
  import display_refresh_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_en,
  input  logic [4*NUM_DIGITS-1:0] i_bcd,
  input  logic                    i_update,
  input  logic [3:0]              i_intensity,
  output logic                    o_busy,
  output logic                    o_serial_dout,
  output logic                    o_serial_load,
  output logic                    o_serial_clk
);

  localparam logic [7:0] DECODE_MASK = 8'((1 << NUM_DIGITS) - 1);
  localparam logic [7:0] SCAN_DATA   = 8'(NUM_DIGITS - 1);
  localparam logic [2:0] LAST_DIGIT  = 3'(NUM_DIGITS - 1);

  state_t      state;
  logic [2:0]  idx;            // position within INIT or DIGITS sequence
  logic        pending;        // refresh requested while not able to serve it
  logic [3:0]  last_intensity; // value most recently sent to the chip
  logic [31:0] bcd_snap;       // digits frozen at DIGITS entry, padded to 8 digits
  logic        in_flight;
  logic        tx_start;
  logic [15:0] tx_word;
  logic        tx_done;

  logic [15:0] init_word;
  logic [15:0] digit_word;
  logic        idle_now;

  // Word for the current init step
  always_comb begin
    init_word = frame_word(ADDR_SHUTDOWN, 8'h01);
    case (idx)
      3'd0:    init_word = frame_word(ADDR_TEST, 8'h00);
      3'd1:    init_word = frame_word(ADDR_DECODE, DECODE_MASK);
      3'd2:    init_word = frame_word(ADDR_SCAN_LIMIT, SCAN_DATA);
      3'd3:    init_word = frame_word(ADDR_INTENSITY, {4'h0, i_intensity});
      default: init_word = frame_word(ADDR_SHUTDOWN, 8'h01);
    endcase
  end

  // Word for the current digit, taken from the snapshot
  always_comb begin
    digit_word = frame_word(ADDR_DIGIT0 + {1'b0, idx}, {4'h0, bcd_snap[{idx, 2'b00} +: 4]});
  end

  // Nothing to do and nothing about to be requested
  always_comb begin
    idle_now = (state == ST_IDLE) && !in_flight && !pending && !i_update &&
               (i_intensity == last_intensity);
  end

  // Sequencing FSM: issues one frame at a time and advances on frame completion
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= ST_INIT;
      idx            <= 3'd0;
      pending        <= 1'b0;
      last_intensity <= 4'h0;
      bcd_snap       <= 32'h0;
      in_flight      <= 1'b0;
      tx_start       <= 1'b0;
      tx_word        <= 16'h0000;
      o_busy         <= 1'b1;
    end else begin
      tx_start <= 1'b0;
      o_busy   <= !idle_now;
      if (i_update) begin
        pending <= 1'b1;
      end

      if (tx_done) begin
        in_flight <= 1'b0;
        case (state)
          ST_INIT: begin
            if (idx == INIT_LAST) begin
              state    <= ST_DIGITS;
              idx      <= 3'd0;
              bcd_snap <= 32'(i_bcd);
            end else begin
              idx <= idx + 3'd1;
            end
          end
          ST_DIGITS: begin
            if (idx == LAST_DIGIT) begin
              state <= ST_IDLE;
              idx   <= 3'd0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
          ST_INTENS: state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end else if (!in_flight && i_en) begin
        case (state)
          ST_INIT: begin
            tx_start  <= 1'b1;
            tx_word   <= init_word;
            in_flight <= 1'b1;
            if (idx == INIT_INTENS_IDX) begin
              last_intensity <= i_intensity;
            end
          end
          ST_DIGITS: begin
            tx_start  <= 1'b1;
            tx_word   <= digit_word;
            in_flight <= 1'b1;
          end
          ST_IDLE: begin
            if (pending || i_update) begin
              state    <= ST_DIGITS;
              idx      <= 3'd0;
              bcd_snap <= 32'(i_bcd);
              pending  <= 1'b0;
            end else if (i_intensity != last_intensity) begin
              state <= ST_INTENS;
            end
          end
          ST_INTENS: begin
            tx_start       <= 1'b1;
            tx_word        <= frame_word(ADDR_INTENSITY, {4'h0, i_intensity});
            last_intensity <= i_intensity;
            in_flight      <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  serial_frame_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (tx_start),
    .i_word  (tx_word),
    .o_done  (tx_done),
    .o_dout  (o_serial_dout),
    .o_load  (o_serial_load),
    .o_sclk  (o_serial_clk)
  );

endmodule

// File: tb/tb_display_refresh_controller.sv
// Purpose: directed bench decoding the serial link back into 16-bit frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_display_refresh_controller;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_en = 1'b1;
  logic [15:0] i_bcd = 16'h1234;
  logic        i_update = 1'b0;
  logic [3:0]  i_intensity = 4'd5;
  logic        o_busy;
  logic        o_serial_dout;
  logic        o_serial_load;
  logic        o_serial_clk;

  int compared = 0;
  int mismatched = 0;

  display_refresh_controller #(
    .NUM_DIGITS (4),
    .CLK_DIV    (2)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_en          (i_en),
    .i_bcd         (i_bcd),
    .i_update      (i_update),
    .i_intensity   (i_intensity),
    .o_busy        (o_busy),
    .o_serial_dout (o_serial_dout),
    .o_serial_load (o_serial_load),
    .o_serial_clk  (o_serial_clk)
  );

  always #5 i_clk = ~i_clk;

  // Link decoder: shift on serial-clock rise, record complete frames on load rise
  logic [15:0] frames[$];
  int          lens[$];
  logic [15:0] sr = 16'h0;
  int          nbits = 0;
  int          low_len = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_load = 1'b1;

  always @(negedge i_clk) begin
    if (o_serial_clk && !prev_sclk) begin
      sr = {sr[14:0], o_serial_dout};
      nbits++;
    end
    if (!o_serial_load) low_len++;
    if (o_serial_load && !prev_load) begin
      if (nbits == 16) begin
        frames.push_back(sr);
        lens.push_back(low_len);
      end
      nbits = 0;
      low_len = 0;
    end
    prev_sclk = o_serial_clk;
    prev_load = o_serial_load;
  end

  logic [15:0] exp_boot [9] = '{16'h0F00, 16'h090F, 16'h0B03, 16'h0A05, 16'h0C01,
                                16'h0104, 16'h0203, 16'h0302, 16'h0401};
  logic [15:0] exp_0959 [4] = '{16'h0109, 16'h0205, 16'h0309, 16'h0400};
  logic [15:0] exp_5678 [4] = '{16'h0108, 16'h0207, 16'h0306, 16'h0405};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_frames();
    frames.delete();
    lens.delete();
  endtask

  task automatic expect_frame(input int i, input logic [15:0] w);
    logic [15:0] got;
    int          len;
    got = 16'hxxxx;
    len = -1;
    if (i < frames.size()) begin
      got = frames[i];
      len = lens[i];
    end
    check($sformatf("frame%0d_word", i), {16'h0, got}, {16'h0, w});
    check($sformatf("frame%0d_load_low_cycles", i), len, 32'd64);
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int c = 0;
    while (frames.size() < n && c < budget) begin
      step();
      c++;
    end
    check(tag, frames.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c = 0;
    while (o_busy !== 1'b0 && c < budget) begin
      step();
      c++;
    end
    check(tag, {31'h0, o_busy}, 32'd0);
  endtask

  task automatic wait_load_low(input int budget, input string tag);
    int c = 0;
    while (o_serial_load !== 1'b0 && c < budget) begin
      step();
      c++;
    end
    check(tag, {31'h0, o_serial_load}, 32'd0);
  endtask

  task automatic pulse_update();
    i_update = 1'b1;
    step();
    i_update = 1'b0;
  endtask

  initial begin
    // Reset levels
    repeat (3) step();
    check("rst_load", {31'h0, o_serial_load}, 32'd1);
    check("rst_sclk", {31'h0, o_serial_clk}, 32'd0);
    check("rst_dout", {31'h0, o_serial_dout}, 32'd0);
    check("rst_busy", {31'h0, o_busy}, 32'd1);
    i_reset = 1'b0;

    // Boot: init sequence then digits of 1234
    wait_frames(9, 2000, "boot_count");
    for (int i = 0; i < 9; i++) expect_frame(i, exp_boot[i]);
    wait_idle(200, "boot_busy_falls");
    repeat (20) step();
    check("boot_no_extra", frames.size(), 9);

    // Refresh on request; later bcd changes ignored
    clear_frames();
    i_bcd = 16'h0959;
    pulse_update();
    check("upd_busy_next_cycle", {31'h0, o_busy}, 32'd1);
    i_bcd = 16'hFFFF;
    wait_frames(4, 1000, "upd_count");
    for (int i = 0; i < 4; i++) expect_frame(i, exp_0959[i]);
    wait_idle(200, "upd_busy_falls");

    // Three requests during a refresh coalesce into one more
    clear_frames();
    i_bcd = 16'h5678;
    pulse_update();
    repeat (10) step();
    for (int i = 0; i < 3; i++) begin
      pulse_update();
      repeat (4) step();
    end
    wait_idle(2000, "coalesce_busy_falls");
    repeat (20) step();
    check("coalesce_count", frames.size(), 8);
    for (int i = 0; i < 8; i++) expect_frame(i, exp_5678[i % 4]);

    // Intensity change, and a second change mid-frame
    clear_frames();
    i_intensity = 4'd12;
    wait_load_low(50, "intens_frame_start");
    repeat (10) step();
    i_intensity = 4'd3;
    wait_idle(1000, "intens_busy_falls");
    repeat (20) step();
    check("intens_count", frames.size(), 2);
    expect_frame(0, 16'h0A0C);
    expect_frame(1, 16'h0A03);

    // Reset in bit 7 of frame 3
    i_reset = 1'b1;
    i_intensity = 4'd5;
    i_bcd = 16'h1234;
    step();
    step();
    i_reset = 1'b0;
    clear_frames();
    wait_frames(3, 1000, "rst_mid_pre_count");
    wait_load_low(50, "rst_mid_frame3_start");
    repeat (34) step();
    check("rst_mid_sclk_high_before", {31'h0, o_serial_clk}, 32'd1);
    i_reset = 1'b1;
    #1;
    check("rst_mid_load", {31'h0, o_serial_load}, 32'd1);
    check("rst_mid_sclk", {31'h0, o_serial_clk}, 32'd0);
    check("rst_mid_busy", {31'h0, o_busy}, 32'd1);
    step();
    step();
    i_reset = 1'b0;
    clear_frames();
    wait_frames(9, 2000, "rst_mid_restart_count");
    for (int i = 0; i < 9; i++) expect_frame(i, exp_boot[i]);
    wait_idle(200, "rst_mid_busy_falls");

    // Enable dropped during init frame 2
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
    clear_frames();
    wait_frames(2, 1000, "en_pre_count");
    wait_load_low(50, "en_frame2_start");
    repeat (20) step();
    i_en = 1'b0;
    repeat (300) step();
    check("en_hold_count", frames.size(), 3);
    check("en_hold_load", {31'h0, o_serial_load}, 32'd1);
    check("en_hold_busy", {31'h0, o_busy}, 32'd1);
    i_en = 1'b1;
    wait_frames(9, 2000, "en_resume_count");
    for (int i = 0; i < 9; i++) expect_frame(i, exp_boot[i]);
    wait_idle(200, "en_busy_falls");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/display_refresh_controller.md
Name: display_refresh_controller

Overview:
- Sequences the serial 7-segment driver chip (MAX7219-style 16-bit register frames) behind the clock core's serial outputs.
- After reset it sends the fixed init sequence, then refreshes digit registers on request and re-sends intensity when it changes.
- It sits between the time/BCD logic and the o_serial_dout/o_serial_load/o_serial_clk pins, and owns all traffic on that link.

Parameters:
- NUM_DIGITS, 4, number of digit registers refreshed (1..8).
- CLK_DIV, 2, i_clk cycles per serial-clock half-period (>=1).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous reset, active-high.
- i_en  in  1  when low, no new frame starts; a frame in flight completes.
- i_bcd  in  4*NUM_DIGITS  digit values; digit k at [4k+3:4k], digit 0 = rightmost.
- i_update  in  1  one-cycle refresh request strobe.
- i_intensity  in  4  display brightness.
- o_busy  out  1  high while init is pending, a frame is active, or work is pending.
- o_serial_dout  out  1  serial data, MSB first.
- o_serial_load  out  1  chip load/CS; idle high; rising edge latches the frame.
- o_serial_clk  out  1  serial clock; idle low.

Behaviour:
- Reset values (asynchronous):
  - o_serial_load=1, o_serial_clk=0, o_serial_dout=0, o_busy=1.
  - State INIT, frame index 0, pending flag 0, last_intensity 0.
- Frame timing (N=CLK_DIV), cycle 0 = first cycle of the frame:
  - load=0 for cycles 0..32N-1.
  - Bit b (15 down to 0) is driven for 2N cycles: clk low N cycles, then high N cycles. Data changes only while clk is low.
  - Cycles 32N..33N-1: clk=0, load=1. The rising edge of load latches the frame.
  - A frame lasts exactly 33N cycles. The next frame may start on the following cycle.
- Frame word: {4'h0, addr[3:0], data[7:0]}.
- States:
  - INIT: sends 5 frames in order:
    - 0x0F00 (test off)
    - 0x09 + (2^NUM_DIGITS-1) (code-B decode)
    - 0x0B + (NUM_DIGITS-1) (scan limit)
    - 0x0A + i_intensity (records last_intensity)
    - 0x0C01 (run)
    - Then goes to DIGITS.
  - DIGITS: i_bcd is snapshotted on entry. Sends NUM_DIGITS frames, addr = k+1, data = {4'h0, bcd_k}, k ascending. Then goes to IDLE.
  - IDLE: o_busy=0 only if nothing is pending and i_intensity == last_intensity. When i_en=1, priority is:
    - (1) pending or i_update → DIGITS (pending cleared)
    - (2) i_intensity != last_intensity → INTENS
  - INTENS: one frame 0x0A + i_intensity sampled at frame start; updates last_intensity; then goes to IDLE.
- i_update arriving in any non-IDLE state sets pending. Multiple requests coalesce into one refresh.
- i_bcd changes during DIGITS have no effect until the next refresh.
- i_en low:
  - The current frame finishes and the state holds at the frame boundary.
  - The INIT/DIGITS index is retained and resumes when i_en returns high.
  - Pending is still captured.
- Reset mid-frame: outputs return to idle levels immediately; the init sequence restarts from frame 0.
- Intensity changing mid-frame is sampled only at the next INTENS frame start.

Decomposition:
- Package display_refresh_pkg:
  - register address constants (DIGIT0..7, DECODE, INTENSITY, SCAN_LIMIT, SHUTDOWN, TEST)
  - state enum
  - frame-word build function
- Sub-module serial_frame_tx:
  - inputs: i_start, i_word[15:0]
  - outputs: o_done (one-cycle pulse on the last frame cycle), dout/load/clk
  - implements the CLK_DIV timing; the controller FSM only sequences words.

Test Plan:
- Reset release, NUM_DIGITS=4, CLK_DIV=2, i_intensity=5, i_bcd=16'h1234, i_en=1 → 9 frames decoded in order: 0F00, 090F, 0B03, 0A05, 0C01, 0104, 0203, 0302, 0401. Each is 66 cycles; o_busy falls after the last.
- Idle, i_bcd=16'h0959, pulse i_update → frames 0109, 0205, 0309, 0400; o_busy high from the next cycle until done.
- Three i_update pulses during one refresh → exactly one additional refresh follows.
- Idle, i_intensity 5→12 → single frame 0A0C; a second change during that frame triggers another INTENS frame.
- Assert i_reset during bit 7 of frame 3 → load=1, clk=0 immediately; after release the sequence restarts at 0F00.
- i_en low midway through INIT frame 2 → frame 2 completes, link idles; i_en high → frames 3 and 4 follow, then digits.
